// File: rtl/tff_seq_counter.sv
// Up/down counter built from a chain of T-trigger stages with parallel load and a wrap flag.
// Optional build macro TFF_SEQ_COUNTER_SAT_EN turns the modulo wrap into saturation at the limits.
module tff_seq_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             y,
    output logic             wrap
);

    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] tog_eff;
    logic             carry;
    logic             at_limit;
    logic             wrap_next;

    // Stage i toggles when every lower stage equals its direction "carry" value (all ones up, all zeros down).
    always_comb begin
        tog   = '0;
        carry = t;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i] = carry;
            carry  = carry & (x ^ q[i]);
        end
    end

    assign at_limit  = x ? (q == '0) : (&q);
    assign wrap_next = t & at_limit;

`ifdef TFF_SEQ_COUNTER_SAT_EN
    assign tog_eff = wrap_next ? '0 : tog;
`else
    assign tog_eff = tog;
`endif

    assign y = ~(x & ~q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= INIT;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= din;
            wrap <= 1'b0;
        end else begin
            q    <= q ^ tog_eff;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_tff_seq_counter.sv
// Scoreboard bench for tff_seq_counter (WIDTH=4, INIT=0): directed vectors push expected q/wrap/y,
// a monitor pops and compares one entry per clock.
module tb_tff_seq_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       t = 1'b0;
    logic       x = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'h0;
    logic [3:0] q;
    logic       y;
    logic       wrap;

    int checks = 0;
    int errors = 0;

`ifdef TFF_SEQ_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        bit       r;
        bit       l;
        bit [3:0] d;
        bit       tt;
        bit       xx;
        bit [3:0] eq;
        bit       ew;
    } vec_t;

    typedef struct {
        bit [3:0] q;
        bit       w;
        bit       y;
        int       idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    tff_seq_counter #(.WIDTH(4), .INIT(4'h0)) dut (
        .clk  (clk),
        .rst  (rst),
        .t    (t),
        .x    (x),
        .load (load),
        .din  (din),
        .q    (q),
        .y    (y),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    function automatic void add(bit r, bit l, bit [3:0] d, bit tt, bit xx, bit [3:0] eq, bit ew);
        vec_t v;
        v.r = r; v.l = l; v.d = d; v.tt = tt; v.xx = xx; v.eq = eq; v.ew = ew;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", e.idx, q, e.q);
                chk("wrap", e.idx, {3'b0, wrap}, {3'b0, e.w});
                chk("y", e.idx, {3'b0, y}, {3'b0, e.y});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        // reset beats load and count
        add(1, 1, 4'hA, 1, 0, 4'h0, 0);
        // 17 up-count edges from 0
        for (int i = 1; i <= 15; i++) add(0, 0, 4'h0, 1, 0, 4'(i), 0);
        add(0, 0, 4'h0, 1, 0, SAT ? 4'hF : 4'h0, 1);
        add(0, 0, 4'h0, 1, 0, SAT ? 4'hF : 4'h1, SAT);
        // load 3 then count down through zero
        add(0, 1, 4'h3, 0, 0, 4'h3, 0);
        add(0, 0, 4'h0, 1, 1, 4'h2, 0);
        add(0, 0, 4'h0, 1, 1, 4'h1, 0);
        add(0, 0, 4'h0, 1, 1, 4'h0, 0);
        add(0, 0, 4'h0, 1, 1, SAT ? 4'h0 : 4'hF, 1);
        // x toggling around 7/8
        add(0, 1, 4'h7, 0, 1, 4'h7, 0);
        add(0, 0, 4'h0, 1, 0, 4'h8, 0);
        add(0, 0, 4'h0, 1, 1, 4'h7, 0);
        add(0, 0, 4'h0, 1, 0, 4'h8, 0);
        add(0, 0, 4'h0, 1, 1, 4'h7, 0);
        // load beats count at a wrap point
        add(0, 1, 4'hF, 0, 0, 4'hF, 0);
        add(0, 1, 4'h5, 1, 0, 4'h5, 0);
        // load clears wrap even when loading a wrap value
        add(0, 1, 4'hF, 0, 0, 4'hF, 0);
        add(0, 0, 4'h0, 1, 0, SAT ? 4'hF : 4'h0, 1);
        add(0, 1, 4'h0, 1, 1, 4'h0, 0);
        // reset mid-count
        add(0, 1, 4'h8, 0, 0, 4'h8, 0);
        add(0, 0, 4'h0, 1, 0, 4'h9, 0);
        add(1, 0, 4'h0, 1, 0, 4'h0, 0);
        add(0, 0, 4'h0, 1, 0, 4'h1, 0);
        // hold with t=0, either direction
        add(0, 0, 4'h0, 0, 1, 4'h1, 0);
        add(0, 0, 4'h0, 0, 0, 4'h1, 0);
        // down from zero after reset
        add(1, 0, 4'h0, 0, 0, 4'h0, 0);
        add(0, 0, 4'h0, 1, 1, SAT ? 4'h0 : 4'hF, 1);
        add(0, 0, 4'h0, 1, 1, SAT ? 4'h0 : 4'hE, SAT);
`ifdef TFF_SEQ_COUNTER_SAT_EN
        add(0, 1, 4'hF, 0, 0, 4'hF, 0);
        add(0, 0, 4'h0, 1, 0, 4'hF, 1);
        add(0, 0, 4'h0, 1, 0, 4'hF, 1);
        add(0, 0, 4'h0, 1, 0, 4'hF, 1);
        add(0, 1, 4'h0, 0, 1, 4'h0, 0);
        add(0, 0, 4'h0, 1, 1, 4'h0, 1);
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            rst  = vecs[i].r;
            load = vecs[i].l;
            din  = vecs[i].d;
            t    = vecs[i].tt;
            x    = vecs[i].xx;
            @(posedge clk);
            e.q   = vecs[i].eq;
            e.w   = vecs[i].ew;
            e.y   = ~(vecs[i].xx & ~vecs[i].eq[3]);
            e.idx = i;
            sb.push_back(e);
            #2;
        end
        rst = 1'b0; load = 1'b0; t = 1'b0; x = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tff_seq_counter.md
TFF_SEQ_COUNTER -- requirements
Module: tff_seq_counter

Interface
REQ-001 Parameter WIDTH, default 4, meaning number of T-trigger stages (legal range 2..16).
REQ-002 Parameter INIT, default 0, meaning WIDTH-bit state value loaded on reset.
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 t  input  1  count enable; stage-0 toggle input.
REQ-006 x  input  1  direction/mode: 0 = count up, 1 = count down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 din  input  WIDTH  parallel load value.
REQ-009 q  output  WIDTH  registered state; q[0] = stage 0 (LSB).
REQ-010 y  output  1  combinational Mealy output.
REQ-011 wrap  output  1  registered one-cycle wrap/limit flag.

Function
REQ-012 Each q[i] SHALL be a T-trigger: on rising clk, q[i] <= q[i] ^ T[i] when neither rst nor load is active.
REQ-013 T[0] SHALL equal t.
REQ-014 T[i] for i>=1 SHALL equal t AND (x ^ q[0]) AND ... AND (x ^ q[i-1]).
REQ-015 As a result, q SHALL increment by 1 per enabled cycle when x=0 and decrement by 1 when x=1, modulo 2^WIDTH.
REQ-016 With t=0 and load=0, q SHALL hold.
REQ-017 y SHALL equal NOT(x AND NOT q[WIDTH-1]), i.e. y=0 only when counting down with MSB clear; y has zero latency from x and q.
REQ-018 load=1 SHALL set q <= din on the next rising edge, regardless of t and x.
REQ-019 Priority on each edge SHALL be rst > load > count.
REQ-020 wrap SHALL go high for exactly the one cycle following an edge where t=1, load=0, rst=0 and either (x=0, q=all-ones) or (x=1, q=0); otherwise wrap SHALL be 0 after every edge.
REQ-021 A load edge SHALL clear wrap, even if din equals a wrap value.
REQ-022 A change of x between edges SHALL take effect at the next edge; no direction state is stored.
REQ-023 Back-to-back wraps SHALL be possible (e.g. WIDTH stages counting through 2^WIDTH values); wrap pulses SHALL not be suppressed.

Reset
REQ-024 On a rising edge with rst=1, q SHALL become INIT and wrap SHALL become 0.
REQ-025 rst SHALL override load and t on the same edge.
REQ-026 Reset mid-count SHALL discard any pending toggle; counting resumes from INIT on the first edge with rst=0.
REQ-027 Between power-up and the first reset edge, outputs are undefined; no asynchronous path from rst SHALL exist.

Configuration
REQ-028 Macro TFF_SEQ_COUNTER_SAT_EN SHALL select saturating mode when defined.
REQ-029 With TFF_SEQ_COUNTER_SAT_EN defined: at q=all-ones with x=0, or q=0 with x=1, an enabled edge SHALL hold q (all T[i] forced 0) and SHALL set wrap for that cycle as a limit indication.
REQ-030 Without TFF_SEQ_COUNTER_SAT_EN: modulo behaviour of REQ-015 and REQ-020 SHALL apply; no saturation logic SHALL be synthesised.
REQ-031 Load, reset and y behaviour SHALL be identical in both builds.

Verification (WIDTH=4, INIT=0 unless stated)
REQ-032 rst=1 one edge, with load=1, din=4'hA, t=1 -> q=4'h0, wrap=0.
REQ-033 t=1, x=0, 17 edges from q=0 -> q steps 1..15,0,1; wrap=1 only the cycle q shows 0.
REQ-034 load din=4'h3 then t=1, x=1 for 4 edges -> q=2,1,0,F; wrap=1 in the cycle q=F; y=0 while q<8 with x=1.
REQ-035 q=4'h7, t=1, toggle x each edge -> q=8,7,8,7; y follows NOT(x AND NOT q[3]) combinationally.
REQ-036 q=4'hF, x=0, t=1, load=1, din=4'h5 same edge -> q=5, wrap=0; rst asserted mid-count at q=9 -> q=0 next edge.
REQ-037 SAT build: q=4'hF, x=0, t=1, 3 edges -> q stays F, wrap=1 each cycle; x=1 at q=0 -> q stays 0, wrap=1.
